relu_out_collector: RTL and testbench
=====================================

Name: relu_out_collector

Overview:
- Downstream stage of the CNN PE + pool/ReLU pipeline.
- Consumes the stream of pooled, ReLU-activated scalars, one per cycle, under a valid/ready handshake.
- Packs PACK_N scalars into one output-buffer word and queues the words in a small FIFO.
- Writes each word to the output feature-map SRAM through a valid/ready write port, generating sequential addresses from a per-layer base address.
- Pads the final partial word at end of layer and signals layer completion.

Parameters:
- DATA_WID, 16: width of one activation scalar.
- PACK_N, 4: scalars per output word; power of two, 2..8.
- FIFO_DEPTH, 4: word FIFO entries; power of two, >=2.
- ADDR_B, 10: output buffer address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a layer, latches base_addr
- base_addr  in  ADDR_B  first write address of the layer
- in_valid  in  1  in_data valid
- in_ready  out  1  collector accepts in_data this cycle
- in_data  in  DATA_WID  pooled/ReLU scalar
- in_last  in  1  qualifies the final scalar of the layer
- wr_valid  out  1  write request valid
- wr_ready  in  1  SRAM accepts write this cycle
- wr_addr  out  ADDR_B  write address
- wr_data  out  PACK_N*DATA_WID  packed word; lane 0 in LSBs
- wr_mask  out  PACK_N  per-lane write enable
- wr_last  out  1  current word is the last of the layer
- busy  out  1  state != IDLE
- done  out  1  one-cycle layer-complete pulse
- word_cnt  out  ADDR_B+1  words written since start

Behaviour:
- Reset: all outputs 0, FIFO emptied, lane index 0, state IDLE. Reset mid-layer aborts the layer; no done pulse is issued.
- Accept event: in_valid && in_ready. Write event: wr_valid && wr_ready.
- FSM IDLE:
  - in_ready=0; in_valid ignored.
  - start -> COLLECT; latch base_addr into the address pointer; clear word_cnt and the lane index.
- FSM COLLECT:
  - in_ready = !fifo_full. No same-cycle pop bypass: in_ready is 0 whenever the FIFO is full, even if a write event occurs that cycle.
  - Each accept stores in_data in the pack register at the current lane and sets that lane's mask bit.
  - Push word to FIFO at the accepting edge when lane==PACK_N-1 or in_last=1; lane resets to 0.
  - Unfilled lanes carry data 0 and mask 0. The FIFO entry stores {data, mask, last}.
  - Accept with in_last=1 -> DRAIN.
- FSM DRAIN:
  - in_ready=0.
  - Write event with wr_last=1 -> DONE.
- FSM DONE: done=1 for exactly one cycle, then -> IDLE.
- start while busy=1 is ignored.
- FIFO:
  - Registered storage; wr_valid = !fifo_empty.
  - wr_data, wr_mask and wr_last present the head entry.
  - A pushed word is visible on wr_valid the cycle after the push edge (minimum latency 1 cycle from the completing accept).
  - The head is stable while wr_valid=1 && wr_ready=0.
- Addressing:
  - wr_addr = address pointer; the pointer increments by 1 on each write event.
  - The pointer wraps modulo 2^ADDR_B (e.g. 0x3FF -> 0x000).
  - word_cnt increments on each write event and does not wrap within a legal layer.
- Throughput: one scalar per cycle sustained with wr_ready=1.
- Ordering: words are written in the order they are formed, lanes in arrival order.

Test Plan:
- Full words: start, base 0x010; scalars 1..8, in_last on 8; wr_ready=1 -> write 0x010 data {4,3,2,1} mask 1111; write 0x011 data {8,7,6,5} mask 1111 wr_last=1; done pulses 1 cycle after that write; word_cnt=2.
- Partial word: 6 scalars 0x0A..0x0F, last on 0x0F -> second write data {0,0,0x0F,0x0E}, mask 0011, wr_last=1.
- Backpressure: wr_ready=0, stream 20 scalars -> in_ready falls after 16 accepts (FIFO full, 4 words); raise wr_ready -> 5 words written in order at consecutive addresses, no lost or duplicated scalar.
- Wrap: base 0x3FF, 8 scalars -> writes at 0x3FF then 0x000.
- Reset mid-layer: assert reset after 5 accepts with wr_ready=0 -> next cycle wr_valid=0, in_ready=0, busy=0, word_cnt=0; no done pulse; a fresh start then works normally.
- Ignore rules: in_valid=1 in IDLE -> not accepted; start pulse during COLLECT -> base address unchanged, layer continues.

Source files
------------

// File: rtl/relu_out_if.sv
// Handshake bundle between the pool/ReLU stream, the collector and the output-buffer SRAM port.
// The master modport is the collector's view; the slave modport is the surrounding pipeline's view.
interface relu_out_if #(
    parameter int unsigned DATA_WID = 16,
    parameter int unsigned PACK_N   = 4,
    parameter int unsigned ADDR_B   = 10
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WID-1:0]          in_data;
    logic                         in_last;
    logic                         wr_valid;
    logic                         wr_ready;
    logic [ADDR_B-1:0]            wr_addr;
    logic [PACK_N*DATA_WID-1:0]   wr_data;
    logic [PACK_N-1:0]            wr_mask;
    logic                         wr_last;

    modport master (
        input  in_valid, in_data, in_last, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data, wr_mask, wr_last
    );

    modport slave (
        output in_valid, in_data, in_last, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data, wr_mask, wr_last
    );
endinterface

// File: rtl/relu_out_collector.sv
// Packs pooled/ReLU scalars into PACK_N-lane words, queues them in a small FIFO and writes
// them to the output feature-map SRAM at sequential addresses from a per-layer base.
module relu_out_collector #(
    parameter int unsigned DATA_WID   = 16,
    parameter int unsigned PACK_N     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_B     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_B-1:0] base_addr,
    relu_out_if.master        bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_B:0]   word_cnt
);

    localparam int unsigned LANE_W  = $clog2(PACK_N);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned WORD_W  = PACK_N * DATA_WID;
    localparam int unsigned ENTRY_W = WORD_W + PACK_N + 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   pack_data_q, pack_data_upd;
    logic [PACK_N-1:0]   pack_mask_q, pack_mask_upd;
    logic [ADDR_B-1:0]   addr_q;
    logic [ADDR_B:0]     word_cnt_q;

    logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic [ENTRY_W-1:0]  head;

    logic fifo_full, fifo_empty, coll_ready, accept, push, pop, begin_layer;

    assign fifo_full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    // No pop bypass: a full FIFO stalls the input even if the SRAM drains a word this cycle.
    assign coll_ready  = (state_q == StCollect) && !fifo_full;
    assign accept      = bus.in_valid && coll_ready;
    assign push        = accept && ((lane_q == LANE_W'(PACK_N - 1)) || bus.in_last);
    assign pop         = !fifo_empty && bus.wr_ready;
    assign begin_layer = (state_q == StIdle) && start;
    assign head        = fifo_mem_q[rd_ptr_q];

    assign bus.in_ready = coll_ready;
    assign bus.wr_valid = !fifo_empty;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = fifo_empty ? '0 : head[ENTRY_W-1 -: WORD_W];
    assign bus.wr_mask  = fifo_empty ? '0 : head[PACK_N:1];
    assign bus.wr_last  = fifo_empty ? 1'b0 : head[0];

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign word_cnt = word_cnt_q;

    // Pack register contents as they would be after storing in_data at the current lane.
    always_comb begin
        pack_data_upd = pack_data_q;
        pack_mask_upd = pack_mask_q;
        for (int unsigned i = 0; i < PACK_N; i++) begin
            if (lane_q == LANE_W'(i)) begin
                pack_data_upd[i*DATA_WID +: DATA_WID] = bus.in_data;
                pack_mask_upd[i]                      = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCollect;
            StCollect: if (accept && bus.in_last) state_d = StDrain;
            StDrain:   if (pop && bus.wr_last) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q      <= '0;
            pack_data_q <= '0;
            pack_mask_q <= '0;
        end else if (begin_layer || push) begin
            lane_q      <= '0;
            pack_data_q <= '0;
            pack_mask_q <= '0;
        end else if (accept) begin
            lane_q      <= lane_q + LANE_W'(1);
            pack_data_q <= pack_data_upd;
            pack_mask_q <= pack_mask_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            word_cnt_q <= '0;
        end else if (begin_layer) begin
            addr_q     <= base_addr;
            word_cnt_q <= '0;
        end else if (pop) begin
            addr_q     <= addr_q + ADDR_B'(1);
            word_cnt_q <= word_cnt_q + (ADDR_B+1)'(1);
        end
    end

    // Storage is not reset; outputs are gated by fifo_empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {pack_data_upd, pack_mask_upd, bus.in_last};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_accept_when_full: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !bus.in_ready);

    a_head_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.wr_valid && !bus.wr_ready) |=> bus.wr_valid && $stable(bus.wr_data)
            && $stable(bus.wr_mask) && $stable(bus.wr_addr) && $stable(bus.wr_last));

endmodule

// File: tb/tb_relu_out_collector.sv
// Bench for relu_out_collector: table of whole layers plus hand-written corner sequences,
// with a scoreboard of expected SRAM writes built from the driven scalars.
module tb_relu_out_collector;

    localparam int unsigned DW = 16;
    localparam int unsigned PN = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned AB = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AB-1:0] base_addr;
    logic          busy;
    logic          done;
    logic [AB:0]   word_cnt;

    relu_out_if #(.DATA_WID(DW), .PACK_N(PN), .ADDR_B(AB)) bus ();

    relu_out_collector #(.DATA_WID(DW), .PACK_N(PN), .FIFO_DEPTH(FD), .ADDR_B(AB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AB-1:0]    addr;
        logic [PN*DW-1:0] data;
        logic [PN-1:0]    mask;
        logic             last;
    } exp_t;

    typedef struct {
        logic [AB-1:0] base;
        int            n;
        logic [DW-1:0] first;
        int            ready_mode;
        int            exp_words;
        logic [AB-1:0] exp_end;
    } vec_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc      = 0;
    int               last_write_cyc = 0;
    int               ready_mode = 1;
    int               m_lane;
    logic [PN*DW-1:0] m_data;
    logic [PN-1:0]    m_mask;
    logic [AB-1:0]    m_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // SRAM write-port model: ready pattern applied a little after each rising edge.
    initial begin
        bus.wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.wr_ready = 1'b0;
                1:       bus.wr_ready = 1'b1;
                default: bus.wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.wr_valid && bus.wr_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 64'(bus.wr_addr), 64'h3ff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                check("wr_data", 64'(bus.wr_data), 64'(e.data));
                check("wr_mask", 64'(bus.wr_mask), 64'(e.mask));
                check("wr_last", 64'(bus.wr_last), 64'(e.last));
                if (bus.wr_last) last_write_cyc = cyc;
            end
        end
    end

    task automatic model_clear(input logic [AB-1:0] b);
        m_lane = 0;
        m_data = '0;
        m_mask = '0;
        m_addr = b;
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        exp_t e;
        m_data[m_lane*DW +: DW] = d;
        m_mask[m_lane] = 1'b1;
        if (m_lane == PN - 1 || l) begin
            e.addr = m_addr;
            e.data = m_data;
            e.mask = m_mask;
            e.last = l;
            sb.push_back(e);
            m_addr = m_addr + 1'b1;
            model_clear(m_addr);
        end else begin
            m_lane++;
        end
    endtask

    task automatic pulse_start(input logic [AB-1:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = '0;
    endtask

    // Holds a scalar until accepted, then records it in the model.
    task automatic send(input logic [DW-1:0] d, input logic l);
        bit acc = 0;
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            guard++;
            if (!acc) begin
                @(posedge clk);
                #1;
            end
        end
        if (!acc) begin
            check("send_timeout", 64'(guard), 64'(0));
        end else begin
            model_accept(d, l);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input int exp_words, input logic [AB-1:0] exp_end);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 400);
        check("done_seen", 64'(done), 64'(1));
        if (done) begin
            check("done_latency", 64'(cyc - last_write_cyc), 64'(1));
            check("word_cnt", 64'(word_cnt), 64'(exp_words));
            check("end_addr", 64'(bus.wr_addr), 64'(exp_end));
            check("sb_empty", 64'(sb.size()), 64'(0));
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'(0));
            check("idle_after_done", 64'(busy), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{base: 10'h010, n: 8,  first: 16'h0001, ready_mode: 1, exp_words: 2, exp_end: 10'h012};
        vecs[1] = '{base: 10'h020, n: 6,  first: 16'h000A, ready_mode: 1, exp_words: 2, exp_end: 10'h022};
        vecs[2] = '{base: 10'h3FF, n: 8,  first: 16'h0100, ready_mode: 1, exp_words: 2, exp_end: 10'h001};
        vecs[3] = '{base: 10'h100, n: 1,  first: 16'hBEEF, ready_mode: 1, exp_words: 1, exp_end: 10'h101};
        vecs[4] = '{base: 10'h200, n: 13, first: 16'h7000, ready_mode: 2, exp_words: 4, exp_end: 10'h204};

        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        model_clear('0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr_valid", 64'(bus.wr_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_word_cnt", 64'(word_cnt), 64'(0));
        check("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
        @(posedge clk);
        #1;

        // Scalars offered while idle must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0055;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_in_ready", 64'(bus.in_ready), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].ready_mode;
            model_clear(vecs[v].base);
            pulse_start(vecs[v].base);
            for (int k = 0; k < vecs[v].n; k++) begin
                send(vecs[v].first + DW'(k), k == vecs[v].n - 1);
            end
            wait_done(vecs[v].exp_words, vecs[v].exp_end);
        end

        // Backpressure: four words fill the FIFO, then the input stalls with no pop bypass.
        ready_mode = 0;
        model_clear(10'h040);
        pulse_start(10'h040);
        for (int k = 1; k <= 16; k++) send(DW'(k), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd17;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
            check("bp_wr_valid", 64'(bus.wr_valid), 64'(1));
            check("bp_head_data", 64'(bus.wr_data), 64'h0004_0003_0002_0001);
            check("bp_addr_hold", 64'(bus.wr_addr), 64'h040);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        @(negedge clk);
        check("bp_no_bypass", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        for (int k = 17; k <= 20; k++) send(DW'(k), k == 20);
        wait_done(5, 10'h045);

        // A second start mid-layer must not move the address pointer.
        ready_mode = 1;
        model_clear(10'h0C0);
        pulse_start(10'h0C0);
        send(16'h0C01, 1'b0);
        send(16'h0C02, 1'b0);
        pulse_start(10'h300);
        check("restart_busy", 64'(busy), 64'(1));
        for (int k = 3; k <= 8; k++) send(16'h0C00 + DW'(k), k == 8);
        wait_done(2, 10'h0C2);

        // Reset mid-layer aborts without a done pulse.
        ready_mode = 0;
        model_clear(10'h080);
        pulse_start(10'h080);
        for (int k = 0; k < 5; k++) send(16'h0800 + DW'(k), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        model_clear('0);
        @(negedge clk);
        check("mid_rst_wr_valid", 64'(bus.wr_valid), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_word_cnt", 64'(word_cnt), 64'(0));
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (done) seen++;
                @(negedge clk);
            end
            check("mid_rst_no_done", 64'(seen), 64'(0));
        end
        @(posedge clk);
        #1;

        ready_mode = 1;
        model_clear(10'h150);
        pulse_start(10'h150);
        for (int k = 0; k < 7; k++) send(16'h1500 + DW'(k), k == 6);
        wait_done(2, 10'h152);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
